// File: rtl/poly_song_reader.sv
// Song reader: walks one song of an external synchronous ROM and dispatches
// note entries to a bank of VOICES note players, with timed waits, pause and loop.
module poly_song_reader #(
  parameter int SONG_SEL_W = 2,
  parameter int ADDR_W     = 5,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int VOICES     = 3,
  parameter int VOICE_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         loop,
  input  logic [SONG_SEL_W-1:0]        song,
  input  logic                         beat_tick,
  input  logic [VOICES-1:0]            voice_busy,
  output logic [SONG_SEL_W+ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W+VOICE_W:0] rom_data,
  output logic [NOTE_W-1:0]            note,
  output logic [DUR_W-1:0]             duration,
  output logic [VOICE_W-1:0]           voice,
  output logic                         new_note,
  output logic                         song_done,
  output logic                         playing,
  output logic [2:0]                   dbg_state
);

  localparam int PAD_W = 1 << VOICE_W;

  typedef enum logic [2:0] {
    S_PAUSED = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_INCR   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [DUR_W-1:0]        wait_q, wait_d;
  logic [SONG_SEL_W-1:0]   song_q, song_d;
  logic [NOTE_W-1:0]       ent_note_q, ent_note_d;
  logic [DUR_W-1:0]        ent_dur_q, ent_dur_d;
  logic [VOICE_W-1:0]      ent_voice_q, ent_voice_d;
  logic [NOTE_W-1:0]       note_q, note_d;
  logic [DUR_W-1:0]        dur_q, dur_d;
  logic [VOICE_W-1:0]      voice_q, voice_d;
  logic                    new_note_q, new_note_d;
  logic                    song_done_q, song_done_d;

  logic                    rd_is_wait;
  logic [NOTE_W-1:0]       rd_note;
  logic [DUR_W-1:0]        rd_dur;
  logic [VOICE_W-1:0]      rd_voice;
  logic                    rd_voice_bad;
  logic [PAD_W-1:0]        busy_pad;

  assign rd_is_wait   = rom_data[NOTE_W+DUR_W+VOICE_W];
  assign rd_note      = rom_data[DUR_W+VOICE_W +: NOTE_W];
  assign rd_dur       = rom_data[VOICE_W +: DUR_W];
  assign rd_voice     = rom_data[VOICE_W-1:0];
  assign rd_voice_bad = ({1'b0, rd_voice} >= (VOICE_W+1)'(VOICES));
  // Padding lets the full voice field index the busy vector safely.
  assign busy_pad     = PAD_W'(voice_busy);

  // Handshake toward the players: new_note acts as valid for note/duration/voice
  // toward voice, and ~voice_busy[voice] acts as ready; a note is issued only in
  // a cycle where the target voice is not busy, and it is never withdrawn except
  // by pause or song change, which abandon the entry before it is issued.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    song_d      = song_q;
    ent_note_d  = ent_note_q;
    ent_dur_d   = ent_dur_q;
    ent_voice_d = ent_voice_q;
    note_d      = note_q;
    dur_d       = dur_q;
    voice_d     = voice_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    if (state_q != S_PAUSED && !play) begin
      state_d = S_PAUSED;
    end else if (state_q != S_PAUSED && song != song_q) begin
      state_d = S_FETCH;
      idx_d   = '0;
      wait_d  = '0;
      song_d  = song;
    end else begin
      case (state_q)
        S_PAUSED: begin
          if (play) begin
            song_d  = song;
            state_d = (wait_q != '0) ? S_WAIT : S_FETCH;
          end
        end
        S_FETCH: begin
          state_d = S_DECODE;
        end
        S_DECODE: begin
          ent_note_d  = rd_note;
          ent_dur_d   = rd_dur;
          ent_voice_d = rd_voice;
          if (rd_is_wait) begin
            if (rd_dur == '0) begin
              state_d = S_INCR;
            end else begin
              wait_d  = rd_dur;
              state_d = S_WAIT;
            end
          end else if (rd_voice_bad) begin
            state_d = S_INCR;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!busy_pad[ent_voice_q]) begin
            new_note_d = 1'b1;
            note_d     = ent_note_q;
            dur_d      = ent_dur_q;
            voice_d    = ent_voice_q;
            state_d    = S_INCR;
          end
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_d = S_INCR;
          end else if (beat_tick) begin
            wait_d = wait_q - DUR_W'(1);
            if (wait_q == DUR_W'(1)) begin
              state_d = S_INCR;
            end
          end
        end
        S_INCR: begin
          idx_d = idx_q + ADDR_W'(1);
          if (idx_q == '1) begin
            song_done_d = 1'b1;
            if (loop) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_PAUSED;
              wait_d  = '0;
            end
          end else begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_PAUSED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_PAUSED;
      idx_q       <= '0;
      wait_q      <= '0;
      song_q      <= '0;
      ent_note_q  <= '0;
      ent_dur_q   <= '0;
      ent_voice_q <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      voice_q     <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      song_q      <= song_d;
      ent_note_q  <= ent_note_d;
      ent_dur_q   <= ent_dur_d;
      ent_voice_q <= ent_voice_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      voice_q     <= voice_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr  = {song_q, idx_q};
  assign note      = note_q;
  assign duration  = dur_q;
  assign voice     = voice_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;
  assign playing   = (state_q != S_PAUSED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_poly_song_reader.sv
// Bench for poly_song_reader: directed timing scenarios plus a randomized song
// whose issued notes are predicted from the song contents alone.
module tb_poly_song_reader;

  localparam int SONG_SEL_W = 2;
  localparam int ADDR_W     = 5;
  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int VOICES     = 3;
  localparam int VOICE_W    = 2;
  localparam int ENT_W      = 1 + NOTE_W + DUR_W + VOICE_W;
  localparam int W          = NOTE_W + DUR_W + VOICE_W;

  logic                         clk;
  logic                         reset;
  logic                         play;
  logic                         loop;
  logic [SONG_SEL_W-1:0]        song;
  logic                         beat_tick;
  logic [VOICES-1:0]            voice_busy;
  logic [SONG_SEL_W+ADDR_W-1:0] rom_addr;
  logic [ENT_W-1:0]             rom_data;
  logic [NOTE_W-1:0]            note;
  logic [DUR_W-1:0]             duration;
  logic [VOICE_W-1:0]           voice;
  logic                         new_note;
  logic                         song_done;
  logic                         playing;
  logic [2:0]                   dbg_state;

  logic [ENT_W-1:0] rom_mem [0:(1<<(SONG_SEL_W+ADDR_W))-1];
  logic [W-1:0]     exp_q[$];
  int               n_cmp;
  int               n_fail;

  poly_song_reader #(
    .SONG_SEL_W(SONG_SEL_W), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
    .DUR_W(DUR_W), .VOICES(VOICES), .VOICE_W(VOICE_W)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .loop(loop), .song(song),
    .beat_tick(beat_tick), .voice_busy(voice_busy), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .duration(duration), .voice(voice),
    .new_note(new_note), .song_done(song_done), .playing(playing),
    .dbg_state(dbg_state)
  );

  // clock / reset block and synchronous song ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [ENT_W-1:0] mk_note(input int n, input int d, input int v);
    logic [NOTE_W-1:0]  nn;
    logic [DUR_W-1:0]   dd;
    logic [VOICE_W-1:0] vv;
    nn = NOTE_W'(n);
    dd = DUR_W'(d);
    vv = VOICE_W'(v);
    return {1'b0, nn, dd, vv};
  endfunction

  function automatic logic [ENT_W-1:0] mk_wait(input int d);
    logic [DUR_W-1:0] dd;
    dd = DUR_W'(d);
    return {1'b1, {NOTE_W{1'b1}}, dd, VOICE_W'(1)};
  endfunction

  task automatic fill_song(input int s, input logic [ENT_W-1:0] val);
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[s * (1 << ADDR_W) + i] = val;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; play = 1'b0; loop = 1'b0; beat_tick = 1'b0;
    voice_busy = '0; song = '0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse_tick();
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
  endtask

  task automatic run_to_done(output int cycles, output logic seen);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 400) begin
      step();
      cycles++;
      if (song_done === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    int          cyc;
    logic        seen;
    int          total;
    int          issued;
    logic [5:0]  rn, rd;
    logic [1:0]  rv;
    n_cmp = 0;
    n_fail = 0;
    for (int s = 0; s < 4; s++) fill_song(s, mk_wait(0));
    reset = 1'b1; play = 1'b0; loop = 1'b0; beat_tick = 1'b0; voice_busy = '0; song = '0;

    // reset state
    do_reset();
    check("rst_note", note, 0);
    check("rst_dur", duration, 0);
    check("rst_voice", voice, 0);
    check("rst_new_note", new_note, 0);
    check("rst_song_done", song_done, 0);
    check("rst_playing", playing, 0);
    check("rst_rom_addr", rom_addr, 0);

    // basic issue: new_note 3 cycles after FETCH
    do_reset();
    rom_mem[8'h20] = mk_note(12, 8, 2);
    song = 2'd1; play = 1'b1;
    step();
    check("basic_fetch_addr", rom_addr, 32'h20);
    check("basic_playing", playing, 1);
    check("basic_nn_c0", new_note, 0);
    step(); check("basic_nn_c1", new_note, 0);
    step(); check("basic_nn_c2", new_note, 0);
    step();
    check("basic_nn_c3", new_note, 1);
    check("basic_note", note, 12);
    check("basic_dur", duration, 8);
    check("basic_voice", voice, 2);
    step();
    check("basic_nn_pulse", new_note, 0);
    check("basic_hold_note", note, 12);
    check("basic_next_addr", rom_addr, 32'h21);

    // wait entry: 3 ticks, then a dur=0 wait that needs no tick
    do_reset();
    fill_song(1, mk_wait(0));
    rom_mem[8'h20] = mk_wait(3);
    rom_mem[8'h21] = mk_wait(0);
    rom_mem[8'h22] = mk_note(5, 1, 0);
    song = 2'd1; play = 1'b1;
    step(3);
    for (int t = 0; t < 3; t++) begin
      repeat (4) begin
        step();
        check("wait_hold_addr", rom_addr, 32'h20);
        check("wait_no_note", new_note, 0);
      end
      pulse_tick();
      check("wait_tick_addr", rom_addr, 32'h20);
    end
    step(); check("wait_adv_addr", rom_addr, 32'h21);
    step(); check("wait0_decode", rom_addr, 32'h21);
    step(); check("wait0_incr", rom_addr, 32'h21);
    step(); check("wait0_adv_addr", rom_addr, 32'h22);
    step(3);
    check("wait_then_note_nn", new_note, 1);
    check("wait_then_note", note, 5);

    // back-pressure on voice 1, then an out-of-range voice that is skipped
    do_reset();
    rom_mem[8'h20] = mk_note(33, 4, 1);
    rom_mem[8'h21] = mk_note(44, 2, 3);
    rom_mem[8'h22] = mk_note(7, 7, 0);
    song = 2'd1; voice_busy = 3'b010; play = 1'b1;
    step(3);
    repeat (10) begin
      step();
      check("bp_held_nn", new_note, 0);
    end
    voice_busy = '0;
    step();
    check("bp_release_nn", new_note, 1);
    check("bp_note", note, 33);
    check("bp_dur", duration, 4);
    check("bp_voice", voice, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("skip_no_nn", new_note, 0);
      check("skip_hold_note", note, 33);
    end
    step();
    check("skip_next_nn", new_note, 1);
    check("skip_next_note", note, 7);
    check("skip_next_dur", duration, 7);
    check("skip_next_voice", voice, 0);

    // pause mid-wait keeps the remaining count
    do_reset();
    rom_mem[8'h20] = mk_wait(4);
    rom_mem[8'h21] = mk_note(9, 9, 0);
    song = 2'd1; play = 1'b1;
    step(3);
    pulse_tick(); step(); pulse_tick(); step();
    play = 1'b0;
    step();
    check("pause_playing", playing, 0);
    check("pause_addr", rom_addr, 32'h20);
    repeat (3) begin
      pulse_tick();
      step();
      check("pause_tick_playing", playing, 0);
      check("pause_tick_addr", rom_addr, 32'h20);
    end
    play = 1'b1;
    step();
    check("resume_playing", playing, 1);
    pulse_tick();
    check("resume_t1_addr", rom_addr, 32'h20);
    repeat (3) begin
      step();
      check("resume_hold_addr", rom_addr, 32'h20);
    end
    pulse_tick();
    check("resume_t2_addr", rom_addr, 32'h20);
    step();
    check("resume_adv_addr", rom_addr, 32'h21);

    // end of song, loop=0
    do_reset();
    fill_song(1, mk_wait(0));
    song = 2'd1; play = 1'b1;
    run_to_done(cyc, seen);
    check("eos0_seen", seen, 1);
    check("eos0_cycles", cyc, 97);
    check("eos0_playing", playing, 0);
    check("eos0_addr", rom_addr, 32'h20);
    play = 1'b0;
    step();
    check("eos0_pulse", song_done, 0);
    check("eos0_stay_paused", playing, 0);

    // end of song, loop=1
    do_reset();
    loop = 1'b1; song = 2'd1; play = 1'b1;
    run_to_done(cyc, seen);
    check("eos1_seen", seen, 1);
    check("eos1_cycles", cyc, 97);
    check("eos1_playing", playing, 1);
    check("eos1_addr", rom_addr, 32'h20);
    step();
    check("eos1_pulse", song_done, 0);
    check("eos1_playing2", playing, 1);
    step(2);
    check("eos1_next_addr", rom_addr, 32'h21);

    // song change mid-wait, then reset while holding in ISSUE
    do_reset();
    fill_song(2, mk_wait(0));
    rom_mem[8'h20] = mk_wait(5);
    rom_mem[8'h40] = mk_note(20, 3, 1);
    rom_mem[8'h41] = mk_note(21, 5, 2);
    song = 2'd1; play = 1'b1;
    step(3);
    pulse_tick(); step();
    song = 2'd2;
    step();
    check("chg_addr", rom_addr, 32'h40);
    check("chg_no_done", song_done, 0);
    check("chg_playing", playing, 1);
    step(3);
    check("chg_nn", new_note, 1);
    check("chg_note", note, 20);
    check("chg_dur", duration, 3);
    check("chg_voice", voice, 1);
    voice_busy = 3'b100;
    step();
    check("chg_next_addr", rom_addr, 32'h41);
    step(4);
    check("issue_held_nn", new_note, 0);
    reset = 1'b1;
    step();
    check("midrst_note", note, 0);
    check("midrst_dur", duration, 0);
    check("midrst_voice", voice, 0);
    check("midrst_new_note", new_note, 0);
    check("midrst_song_done", song_done, 0);
    check("midrst_playing", playing, 0);
    check("midrst_rom_addr", rom_addr, 0);
    reset = 1'b0;

    // randomized song 3 against a song-order scoreboard
    do_reset();
    exp_q.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      if ($urandom_range(0, 9) < 3) begin
        rom_mem[8'h60 + i] = mk_wait($urandom_range(0, 3));
      end else begin
        rn = 6'($urandom_range(0, 63));
        rd = 6'($urandom_range(0, 63));
        rv = 2'($urandom_range(0, 3));
        rom_mem[8'h60 + i] = mk_note(int'(rn), int'(rd), int'(rv));
        if (rv < 2'd3) exp_q.push_back({rn, rd, rv});
      end
    end
    total = exp_q.size();
    issued = 0;
    seen = 1'b0;
    cyc = 0;
    song = 2'd3; play = 1'b1;
    while (!seen && cyc < 20000) begin
      step();
      cyc++;
      if (new_note === 1'b1) begin
        issued++;
        if (exp_q.size() != 0) check("sb_note", {note, duration, voice}, exp_q.pop_front());
      end
      if (song_done === 1'b1) begin
        seen = 1'b1;
        play = 1'b0;
      end
      voice_busy = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      beat_tick = ($urandom_range(0, 2) == 0);
    end
    check("sb_done_seen", seen, 1);
    check("sb_issue_count", issued, total);
    step(3);
    check("sb_stopped", playing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
